montgomery_exp: RTL and testbench

Modular-exponentiation sequencer that drives an external `montgomery` multiplier through its `start`/`done` handshake, performing the same operation sequence a bench would issue by hand. It computes A = X^E in the Montgomery domain with left-to-right square-and-multiply. It sits between the RSA top level, which supplies operands already in Montgomery form, and one `montgomery` instance, which it owns exclusively.

---
 rtl/montgomery_exp.sv | 128 ++++++++++++
 tb/tb_montgomery_exp.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/montgomery_exp.sv
// Left-to-right square-and-multiply sequencer computing A = X^E in the
// Montgomery domain by driving an external montgomery multiplier through
// its start/done handshake. All outputs are registered.
module montgomery_exp #(
   parameter int WIDTH     = 1024,
   parameter int EXP_WIDTH = 1024
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 start,
   input  logic [WIDTH-1:0]     in_x,
   input  logic [EXP_WIDTH-1:0] in_e,
   input  logic [WIDTH-1:0]     in_m,
   input  logic [WIDTH-1:0]     in_r,
   output logic [WIDTH-1:0]     result,
   output logic                 done,
   output logic                 busy,
   output logic                 mul_start,
   output logic [WIDTH-1:0]     mul_a,
   output logic [WIDTH-1:0]     mul_b,
   output logic [WIDTH-1:0]     mul_m,
   input  logic [WIDTH-1:0]     mul_result,
   input  logic                 mul_done
);

   localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

   typedef enum logic [2:0] {
      IDLE,
      SQ_REQ,
      SQ_WAIT,
      MUL_REQ,
      MUL_WAIT,
      DONE
   } state_t;

   state_t                state;
   logic [WIDTH-1:0]      x;
   logic [EXP_WIDTH-1:0]  e;
   logic [IW-1:0]         idx;

   // Sequencer: operands and mul_start are loaded on the edge that enters a
   // REQ state, so they are already valid (and registered) during that REQ
   // cycle. The accumulator A lives in mul_a, which always holds the latest
   // product by the time it is needed again.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         x         <= '0;
         e         <= '0;
         idx       <= '0;
         result    <= '0;
         done      <= 1'b0;
         busy      <= 1'b0;
         mul_start <= 1'b0;
         mul_a     <= '0;
         mul_b     <= '0;
         mul_m     <= '0;
      end else begin
         mul_start <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  x         <= in_x;
                  e         <= in_e;
                  idx       <= IW'(EXP_WIDTH - 1);
                  mul_a     <= in_r;
                  mul_b     <= in_r;
                  mul_m     <= in_m;
                  mul_start <= 1'b1;
                  busy      <= 1'b1;
                  state     <= SQ_REQ;
               end
            end
            SQ_REQ: begin
               state <= SQ_WAIT;
            end
            SQ_WAIT: begin
               if (mul_done) begin
                  if (e[idx]) begin
                     mul_a     <= mul_result;
                     mul_b     <= x;
                     mul_start <= 1'b1;
                     state     <= MUL_REQ;
                  end else if (idx == '0) begin
                     result <= mul_result;
                     done   <= 1'b1;
                     state  <= DONE;
                  end else begin
                     idx       <= idx - 1'b1;
                     mul_a     <= mul_result;
                     mul_b     <= mul_result;
                     mul_start <= 1'b1;
                     state     <= SQ_REQ;
                  end
               end
            end
            MUL_REQ: begin
               state <= MUL_WAIT;
            end
            MUL_WAIT: begin
               if (mul_done) begin
                  if (idx == '0) begin
                     result <= mul_result;
                     done   <= 1'b1;
                     state  <= DONE;
                  end else begin
                     idx       <= idx - 1'b1;
                     mul_a     <= mul_result;
                     mul_b     <= mul_result;
                     mul_start <= 1'b1;
                     state     <= SQ_REQ;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_montgomery_exp.sv
// Bench for montgomery_exp: behavioural Montgomery multiplier with
// programmable latency, a reference model computing X^E mod M from plain
// modular arithmetic, and one compare process checking every cycle.
module tb_montgomery_exp;

   localparam int         EW  = 8;
   localparam int         MOD = 197;      // 0xC5
   localparam int         RM  = 59;       // 0x3B = 2^8 mod 0xC5

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       start = 1'b0;
   logic [7:0] in_x = '0, in_e = '0, in_m = '0, in_r = '0;
   logic [7:0] result, mul_a, mul_b, mul_m, mul_result;
   logic       done, busy, mul_start, mul_done;

   logic       mdl_done = 1'b0, inj_done = 1'b0;
   logic [7:0] mdl_res = '0, inj_res = '0;
   assign mul_done   = mdl_done | inj_done;
   assign mul_result = inj_done ? inj_res : mdl_res;

   montgomery_exp #(.WIDTH(8), .EXP_WIDTH(8)) dut (
      .clk(clk), .resetn(resetn), .start(start),
      .in_x(in_x), .in_e(in_e), .in_m(in_m), .in_r(in_r),
      .result(result), .done(done), .busy(busy),
      .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m),
      .mul_result(mul_result), .mul_done(mul_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   // ---------------- reference arithmetic ----------------
   function automatic int rinv();
      for (int r = 1; r < MOD; r++)
         if ((256 * r) % MOD == 1) return r;
      return 0;
   endfunction

   function automatic int mont(input int a, input int b);
      return (a * b * rinv()) % MOD;
   endfunction

   // X^E in Montgomery form via plain repeated multiplication
   function automatic int exp_ref(input int xm, input int ev);
      int xp, p;
      xp = (xm * rinv()) % MOD;
      p  = 1;
      for (int k = 0; k < ev; k++) p = (p * xp) % MOD;
      return (p * 256) % MOD;
   endfunction

   // ---------------- driver-owned run description ----------------
   int lat = 1, in_run = 0, run_id = 0;
   int arm_x = 0, arm_e = 0, arm_l = 1, arm_t0 = 0;
   int lit_res = -1, lit_nops = -1, lit_dt = -1, lit_lastb = -1;

   // ---------------- monitor-owned state ----------------
   int vectors = 0, miscompares = 0;
   int ops_seen = 0, obs_res = 0;

   typedef struct { int a; int b; } op_t;

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   // behavioural multiplier: mul_done L cycles after the mul_start cycle
   initial begin : mul_model
      int ta, tb;
      forever begin
         @(negedge clk);
         if (resetn && mul_start) begin
            ta = mul_a;
            tb = mul_b;
            repeat (lat) @(posedge clk);
            #1;
            mdl_res  = 8'(mont(ta, tb));
            mdl_done = 1'b1;
            @(posedge clk);
            #1 mdl_done = 1'b0;
         end
      end
   end

   // single compare process
   initial begin : monitor
      int   seen_id, t0, tdone, exp_n, exp_res, mon_lat, acc, last_a, last_b;
      bit   eb, ed;
      op_t  o;
      op_t  q[$];
      seen_id = 0; t0 = 0; tdone = -1; exp_n = 0; exp_res = 0; mon_lat = 1;
      last_a = 0; last_b = 0;
      forever begin
         @(negedge clk);
         if (run_id != seen_id) begin
            seen_id = run_id;
            q.delete();
            acc = RM;
            for (int i = EW - 1; i >= 0; i--) begin
               o.a = acc; o.b = acc; q.push_back(o);
               acc = mont(acc, acc);
               if (((arm_e >> i) & 1) == 1) begin
                  o.a = acc; o.b = arm_x; q.push_back(o);
                  acc = mont(acc, arm_x);
               end
            end
            exp_n    = q.size();
            exp_res  = exp_ref(arm_x, arm_e);
            t0       = arm_t0;
            mon_lat  = arm_l;
            tdone    = t0 + exp_n * (arm_l + 1);
            ops_seen = 0;
            chk("model_agree", acc, exp_res);
            if (lit_res >= 0) chk("model_pin", exp_res, lit_res);
         end
         if (!resetn) begin
            chk("rst_result", result, 0);
            chk("rst_done", done, 0);
            chk("rst_busy", busy, 0);
            chk("rst_mul_start", mul_start, 0);
            chk("rst_mul_a", mul_a, 0);
            chk("rst_mul_b", mul_b, 0);
            chk("rst_mul_m", mul_m, 0);
            obs_res = 0; last_a = 0; last_b = 0;
         end else begin
            eb = (in_run != 0) && cyc >= t0 && cyc <= tdone;
            ed = (in_run != 0) && cyc == tdone;
            chk("busy", busy, eb);
            chk("done", done, ed);
            if (mul_start) begin
               chk("op_cycle", cyc, t0 + ops_seen * (mon_lat + 1));
               if (q.size() == 0) chk("op_extra", ops_seen + 1, exp_n);
               else begin
                  o = q.pop_front();
                  chk("mul_a", mul_a, o.a);
                  chk("mul_b", mul_b, o.b);
               end
               chk("mul_m", mul_m, MOD);
               last_a = mul_a; last_b = mul_b;
               ops_seen++;
            end else if (busy && !done) begin
               chk("hold_mul_a", mul_a, last_a);
               chk("hold_mul_b", mul_b, last_b);
            end
            if (done) begin
               chk("result", result, exp_res);
               chk("op_count", ops_seen, exp_n);
               if (lit_res >= 0)   chk("result_lit", result, lit_res);
               if (lit_nops >= 0)  chk("ops_lit", ops_seen, lit_nops);
               if (lit_dt >= 0)    chk("done_cycle_lit", cyc - t0 + 1, lit_dt);
               if (lit_lastb >= 0) chk("last_mul_b_lit", last_b, lit_lastb);
               obs_res = result;
            end else begin
               chk("result_hold", result, obs_res);
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic arm(input int x, input int e, input int l, input int t0v,
                      input int lres, input int lnops, input int ldt, input int llb);
      lat = l; arm_x = x; arm_e = e; arm_l = l; arm_t0 = t0v;
      lit_res = lres; lit_nops = lnops; lit_dt = ldt; lit_lastb = llb;
      in_run = 1;
      run_id++;
   endtask

   task automatic scramble_inputs();
      in_x = 8'($urandom); in_e = 8'($urandom);
      in_m = 8'($urandom) | 8'h01; in_r = 8'($urandom);
   endtask

   // wait for done; inj>0 forces a spurious mul_done during the inj-th REQ cycle
   task automatic wait_done(input int inj);
      int nreq;
      nreq = 0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         #1;
         if (done) return;
         if (inj > 0 && mul_start) begin
            nreq++;
            if (nreq == inj) begin
               inj_res  = 8'h5A;
               inj_done = 1'b1;
            end
         end else begin
            inj_done = 1'b0;
         end
      end
      $display("FAIL timeout: no done within 2000 cycles (cycle %0d)", cyc);
      $fatal(1, "timeout");
   endtask

   task automatic run(input int x, input int e, input int l, input int lres,
                      input int lnops, input int ldt, input int llb, input int inj);
      @(negedge clk);
      #1;
      in_x = 8'(x); in_e = 8'(e); in_m = 8'(MOD); in_r = 8'(RM);
      start = 1'b1;
      arm(x, e, l, cyc + 1, lres, lnops, ldt, llb);
      @(posedge clk);
      #1;
      start = 1'b0;
      scramble_inputs();
      wait_done(inj);
   endtask

   initial begin : driver
      int x1, x2, ok;
      repeat (3) @(negedge clk);
      #1 resetn = 1'b1;
      repeat (2) @(negedge clk);

      // directed runs
      run(8'h50, 8'h00, 3, 8'h3B, 8, 33, -1, 0);
      run(8'h50, 8'h01, 3, 8'h50, 9, 37, 8'h50, 0);
      run(8'h50, 8'hFF, 1, -1, 16, 1 + 16 * 2, 8'h50, 0);
      run(8'h50, 8'hFF, 5, -1, 16, 1 + 16 * 6, 8'h50, 0);

      // randomized runs
      for (int n = 0; n < 6; n++)
         run(int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, 255)),
             int'($urandom_range(1, 4)), -1, -1, -1, -1, 0);

      // start held high for the whole run, inputs scrambled mid-run
      x1 = int'($urandom_range(0, MOD - 1));
      @(negedge clk);
      #1;
      in_x = 8'(x1); in_e = 8'h81; in_m = 8'(MOD); in_r = 8'(RM);
      start = 1'b1;
      arm(x1, 8'h81, 2, cyc + 1, -1, 10, -1, -1);
      ok = 0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         #1;
         if (done) begin ok = 1; break; end
         scramble_inputs();
      end
      if (ok == 0) begin
         $display("FAIL timeout: hammered run never finished (cycle %0d)", cyc);
         $fatal(1, "timeout");
      end
      // start still high: the follow-on run is accepted after the idle cycle
      x2 = int'($urandom_range(0, MOD - 1));
      in_x = 8'(x2); in_e = 8'h3C; in_m = 8'(MOD); in_r = 8'(RM);
      arm(x2, 8'h3C, 2, cyc + 2, -1, 12, -1, -1);
      @(posedge clk);
      @(posedge clk);
      #1;
      start = 1'b0;
      scramble_inputs();
      wait_done(0);

      // spurious mul_done in IDLE, then in the third REQ cycle of a run
      @(negedge clk);
      #1;
      inj_res = 8'hA7; inj_done = 1'b1;
      @(negedge clk);
      #1 inj_done = 1'b0;
      run(int'($urandom_range(0, MOD - 1)), 8'hA5, 2, -1, 12, 1 + 12 * 3, -1, 3);

      // reset during the 5th squaring wait
      @(negedge clk);
      #1;
      in_x = 8'h50; in_e = 8'h00; in_m = 8'(MOD); in_r = 8'(RM);
      start = 1'b1;
      arm(8'h50, 8'h00, 3, cyc + 1, -1, -1, -1, -1);
      @(posedge clk);
      #1 start = 1'b0;
      ok = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         #1;
         if (ops_seen >= 5) begin ok = 1; break; end
      end
      if (ok == 0) begin
         $display("FAIL timeout: fifth operation never issued (cycle %0d)", cyc);
         $fatal(1, "timeout");
      end
      @(posedge clk);
      #2;
      resetn = 1'b0;
      in_run = 0;
      repeat (3) @(negedge clk);
      #1 resetn = 1'b1;
      repeat (8) @(negedge clk);
      run(8'h50, 8'h01, 3, 8'h50, 9, 37, 8'h50, 0);

      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
